// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and 128x96 frame-buffer geometry for the VGA scan-out blocks.
package vga_pkg;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_VIS + H_FP;
  localparam int H_SYNC_STOP  = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VIS + V_FP;
  localparam int V_SYNC_STOP  = V_SYNC_START + V_SYNC;

  localparam int SCALE  = 5;
  localparam int MEM_W  = 128;
  localparam int MEM_H  = 96;
  localparam int COL_W  = $clog2(MEM_W);
  localparam int ROW_W  = $clog2(MEM_H);
  localparam int ADDR_W = ROW_W + COL_W;
  localparam int H_W    = $clog2(H_TOTAL);
  localparam int V_W    = $clog2(V_TOTAL);
  localparam int SUB_W  = $clog2(SCALE);

  typedef logic [H_W-1:0]    hcnt_t;
  typedef logic [V_W-1:0]    vcnt_t;
  typedef logic [SUB_W-1:0]  sub_t;
  typedef logic [COL_W-1:0]  col_t;
  typedef logic [ROW_W-1:0]  row_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam hcnt_t H_LAST     = hcnt_t'(H_TOTAL - 1);
  localparam hcnt_t H_VIS_END  = hcnt_t'(H_VIS);
  localparam hcnt_t H_VIS_LAST = hcnt_t'(H_VIS - 1);
  localparam hcnt_t H_HS_BEG   = hcnt_t'(H_SYNC_START);
  localparam hcnt_t H_HS_END   = hcnt_t'(H_SYNC_STOP);
  localparam vcnt_t V_LAST     = vcnt_t'(V_TOTAL - 1);
  localparam vcnt_t V_VIS_END  = vcnt_t'(V_VIS);
  localparam vcnt_t V_VIS_LAST = vcnt_t'(V_VIS - 1);
  localparam vcnt_t V_VS_BEG   = vcnt_t'(V_SYNC_START);
  localparam vcnt_t V_VS_END   = vcnt_t'(V_SYNC_STOP);
  localparam sub_t  SUB_LAST   = sub_t'(SCALE - 1);

  // First pipeline stage: blanking and sync flags travelling with the RAM address.
  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
  } s1_t;

  // MEM_W is a power of two, so row*MEM_W + col is a plain concatenation.
  function automatic addr_t pix_addr(input row_t row, input col_t col);
    return {row, col};
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-tick divider plus 800x525 h/v raster counters with visible and sync decode.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic  CLK,
  input  logic  RESET_N,
  output logic  tick,
  output hcnt_t h,
  output vcnt_t v,
  output logic  line_end,
  output logic  frame_end,
  output logic  visible,
  output logic  hsync_act,
  output logic  vsync_act
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;

  assign tick      = (div == DIV_LAST);
  assign line_end  = (h == H_LAST);
  assign frame_end = line_end && (v == V_LAST);
  assign visible   = (h < H_VIS_END) && (v < V_VIS_END);
  assign hsync_act = (h >= H_HS_BEG) && (h < H_HS_END);
  assign vsync_act = (v >= V_VS_BEG) && (v < V_VS_END);

  // NOTE: reset is sampled on the clock edge, so it lives inside the edge-triggered block
  // rather than in the sensitivity list.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        if (line_end) begin
          h <= '0;
          v <= frame_end ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vga_scan_ctrl.sv
// Scan-out of the 128x96 RGB frame buffer at 5x5 upscale onto 640x480@60 VGA pins.
// Optional build macro VGA_TEST_PATTERN_EN adds PATTERN_SEL for an 8-bar colour test pattern.
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_EN,
  input  logic              RED_IN,
  input  logic              GREEN_IN,
  input  logic              BLUE_IN,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              PATTERN_SEL,
`endif
  output logic              VGA_RED,
  output logic              VGA_GREEN,
  output logic              VGA_BLUE,
  output logic              VGA_HSYNC,
  output logic              VGA_VSYNC,
  output logic              FRAME_START
);

  logic  tick, line_end, frame_end, visible, hsync_act, vsync_act;
  hcnt_t h;
  vcnt_t v;
  sub_t  hsub, vsub;
  col_t  col;
  row_t  row;
  s1_t   s1;
  logic [2:0] pix_rgb;

  vga_timing_gen #(.CLK_DIV(CLK_DIV)) u_timing (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .tick      (tick),
    .h         (h),
    .v         (v),
    .line_end  (line_end),
    .frame_end (frame_end),
    .visible   (visible),
    .hsync_act (hsync_act),
    .vsync_act (vsync_act)
  );

  // Sub-pixel counters replace h/5 and v/5; row is cleared after the last visible line so
  // the address never leaves the 96 stored rows during vertical blanking.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      hsub <= '0;
      col  <= '0;
      vsub <= '0;
      row  <= '0;
    end else if (tick) begin
      if (line_end) begin
        hsub <= '0;
        col  <= '0;
        if (frame_end || v == V_VIS_LAST) begin
          vsub <= '0;
          row  <= '0;
        end else if (v < V_VIS_END) begin
          if (vsub == SUB_LAST) begin
            vsub <= '0;
            row  <= row + 1'b1;
          end else begin
            vsub <= vsub + 1'b1;
          end
        end
      end else if (h == H_VIS_LAST) begin
        hsub <= '0;
        col  <= '0;
      end else if (h < H_VIS_END) begin
        if (hsub == SUB_LAST) begin
          hsub <= '0;
          col  <= col + 1'b1;
        end else begin
          hsub <= hsub + 1'b1;
        end
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar1;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      bar1 <= '0;
    end else if (tick) begin
      bar1 <= col[COL_W-1 -: 3];
    end
  end
`endif

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    pix_rgb = {RED_IN, GREEN_IN, BLUE_IN};
`ifdef VGA_TEST_PATTERN_EN
    if (PATTERN_SEL) pix_rgb = bar1;
`endif
  end

  // Stage 1 issues the address; the RAM answers one CLK later, well before stage 2's tick.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      RAM_ADDR    <= '0;
      RAM_EN      <= 1'b0;
      s1          <= '0;
      VGA_RED     <= 1'b0;
      VGA_GREEN   <= 1'b0;
      VGA_BLUE    <= 1'b0;
      VGA_HSYNC   <= 1'b1;
      VGA_VSYNC   <= 1'b1;
      FRAME_START <= 1'b0;
    end else begin
      RAM_EN      <= 1'b1;
      FRAME_START <= tick && (h == '0) && (v == '0);
      if (tick) begin
        RAM_ADDR <= pix_addr(row, col);
        s1       <= '{vis: visible, hs: hsync_act, vs: vsync_act};
        {VGA_RED, VGA_GREEN, VGA_BLUE} <= s1.vis ? pix_rgb : 3'b000;
        VGA_HSYNC <= ~s1.hs;
        VGA_VSYNC <= ~s1.vs;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Self-checking bench for vga_scan_ctrl: reset values, line timing, address sequence, colour and restart.
module tb_vga_scan_ctrl;

  localparam int SCAN_T = 9600;   // twelve full lines of pixel ticks
  localparam int MAXT   = 9700;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [13:0] RAM_ADDR;
  logic        RAM_EN;
  logic        RED_IN = 1'b0, GREEN_IN = 1'b0, BLUE_IN = 1'b0;
  logic        pattern_sel = 1'b0;
  logic        VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HSYNC, VGA_VSYNC, FRAME_START;

  int n_checks = 0;
  int n_errors = 0;

  vga_scan_ctrl dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .RAM_ADDR    (RAM_ADDR),
    .RAM_EN      (RAM_EN),
    .RED_IN      (RED_IN),
    .GREEN_IN    (GREEN_IN),
    .BLUE_IN     (BLUE_IN),
`ifdef VGA_TEST_PATTERN_EN
    .PATTERN_SEL (pattern_sel),
`endif
    .VGA_RED     (VGA_RED),
    .VGA_GREEN   (VGA_GREEN),
    .VGA_BLUE    (VGA_BLUE),
    .VGA_HSYNC   (VGA_HSYNC),
    .VGA_VSYNC   (VGA_VSYNC),
    .FRAME_START (FRAME_START)
  );

  always #5 CLK = ~CLK;

  // Frame-buffer contents: red only at 129, green only at 2, blue on odd addresses of row 0.
  function automatic logic [2:0] mem_rgb(input logic [13:0] a);
    return {a == 14'd129, a == 14'd2, (a < 14'd128) && a[0]};
  endfunction

  // Three 1-bit RAMs with one CLK read latency.
  always @(posedge CLK) begin
    if (RAM_EN) {RED_IN, GREEN_IN, BLUE_IN} <= mem_rgb(RAM_ADDR);
  end

  logic [13:0] cap_addr [MAXT];
  logic [2:0]  cap_rgb  [MAXT];
  logic        cap_hs   [MAXT];
  int fs_first, fs_count, n_fall, hs_rise, vs_low, ram_en_first;
  int hs_fall [2];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " ram_addr"}, int'(RAM_ADDR), 0);
    check({tag, " ram_en"}, int'(RAM_EN), 0);
    check({tag, " rgb"}, int'({VGA_RED, VGA_GREEN, VGA_BLUE}), 0);
    check({tag, " hsync"}, int'(VGA_HSYNC), 1);
    check({tag, " vsync"}, int'(VGA_VSYNC), 1);
    check({tag, " frame_start"}, int'(FRAME_START), 0);
  endtask

  // Releases reset and samples each CLK on the falling edge. After release edge n, an even n>=2
  // shows the address for pixel tick (n-2)/2 and an even n>=4 shows pins for tick (n-4)/2.
  task automatic run_scan(input int nt);
    logic prev_hs;
    fs_first = -1; fs_count = 0; n_fall = 0; hs_rise = -1; vs_low = 0;
    hs_fall[0] = -1; hs_fall[1] = -1;
    prev_hs = 1'b1;
    RESET_N = 1'b1;
    for (int n = 1; n <= 2 * nt + 4; n++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (n == 1) ram_en_first = int'(RAM_EN);
      if (FRAME_START) begin
        fs_count++;
        if (fs_first < 0) fs_first = n;
      end
      if (!VGA_VSYNC) vs_low++;
      if (prev_hs && !VGA_HSYNC && n_fall < 2) begin
        hs_fall[n_fall] = n;
        n_fall++;
      end
      if (!prev_hs && VGA_HSYNC && hs_rise < 0) hs_rise = n;
      prev_hs = VGA_HSYNC;
      if (n >= 2 && n % 2 == 0 && (n - 2) / 2 < MAXT) cap_addr[(n-2)/2] = RAM_ADDR;
      if (n >= 4 && n % 2 == 0 && (n - 4) / 2 < MAXT) begin
        cap_rgb[(n-4)/2] = {VGA_RED, VGA_GREEN, VGA_BLUE};
        cap_hs[(n-4)/2]  = VGA_HSYNC;
      end
    end
  endtask

  // One-CLK reset pulse, then a restart that must begin again at (0,0).
  task automatic pulse_and_restart(input string tag, input int nt);
    RESET_N = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check_reset(tag);
    run_scan(nt);
    check({tag, " frame_start edge"}, fs_first, 2);
    check({tag, " addr tick0"}, int'(cap_addr[0]), 0);
    check({tag, " addr tick4"}, int'(cap_addr[4]), 0);
    check({tag, " addr tick5"}, int'(cap_addr[5]), 1);
    check({tag, " hsync tick0"}, int'(cap_hs[0]), 1);
  endtask

  typedef struct {
    int h;
    int v;
    bit chk_addr;
    int addr;
    int rgb;
    int hs;
  } vec_t;

  vec_t vecs [16];

  initial begin
    int t, h, v, bad_a, bad_c, bad_h, hi_addr, reds;
    logic [13:0] ea;
    logic [2:0]  ec;

    vecs = '{
      '{h:0,   v:0,  chk_addr:1'b1, addr:0,   rgb:0, hs:1},
      '{h:5,   v:0,  chk_addr:1'b1, addr:1,   rgb:1, hs:1},
      '{h:10,  v:0,  chk_addr:1'b1, addr:2,   rgb:2, hs:1},
      '{h:14,  v:4,  chk_addr:1'b1, addr:2,   rgb:2, hs:1},
      '{h:639, v:0,  chk_addr:1'b1, addr:127, rgb:1, hs:1},
      '{h:640, v:0,  chk_addr:1'b0, addr:0,   rgb:0, hs:1},
      '{h:655, v:0,  chk_addr:1'b0, addr:0,   rgb:0, hs:1},
      '{h:656, v:0,  chk_addr:1'b0, addr:0,   rgb:0, hs:0},
      '{h:751, v:1,  chk_addr:1'b0, addr:0,   rgb:0, hs:0},
      '{h:752, v:1,  chk_addr:1'b0, addr:0,   rgb:0, hs:1},
      '{h:4,   v:5,  chk_addr:1'b1, addr:128, rgb:0, hs:1},
      '{h:5,   v:5,  chk_addr:1'b1, addr:129, rgb:4, hs:1},
      '{h:9,   v:9,  chk_addr:1'b1, addr:129, rgb:4, hs:1},
      '{h:10,  v:5,  chk_addr:1'b1, addr:130, rgb:0, hs:1},
      '{h:0,   v:10, chk_addr:1'b1, addr:256, rgb:0, hs:1},
      '{h:639, v:11, chk_addr:1'b1, addr:383, rgb:0, hs:1}
    };

    RESET_N = 1'b0;
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    check_reset("por");

    run_scan(SCAN_T);
    check("ram_en after release", ram_en_first, 1);
    check("first frame_start edge", fs_first, 2);
    check("frame_start pulses", fs_count, 1);
    check("hsync first fall edge", hs_fall[0], 1316);
    check("hsync first rise edge", hs_rise, 1316 + 192);
    check("hsync second fall edge", hs_fall[1], 1316 + 1600);
    check("vsync low samples", vs_low, 0);

    foreach (vecs[i]) begin
      t = vecs[i].v * 800 + vecs[i].h;
      if (vecs[i].chk_addr)
        check($sformatf("vec%0d addr", i), int'(cap_addr[t]), vecs[i].addr);
      check($sformatf("vec%0d rgb", i), int'(cap_rgb[t]), vecs[i].rgb);
      check($sformatf("vec%0d hsync", i), int'(cap_hs[t]), vecs[i].hs);
    end

    hi_addr = 0;
    reds = 0;
    for (int line = 0; line < 12; line++) begin
      bad_a = 0; bad_c = 0; bad_h = 0;
      for (int x = 0; x < 800; x++) begin
        t = line * 800 + x;
        h = x;
        v = line;
        ea = 14'((v / 5) * 128 + h / 5);
        ec = (h < 640 && v < 480) ? mem_rgb(ea) : 3'b000;
        if (h < 640 && cap_addr[t] !== ea) bad_a++;
        if (cap_rgb[t] !== ec) bad_c++;
        if (cap_hs[t] !== !(h >= 656 && h < 752)) bad_h++;
        if (cap_addr[t] > 14'd12287) hi_addr++;
        if (cap_rgb[t][2]) reds++;
      end
      check($sformatf("addr errors line %0d", line), bad_a, 0);
      check($sformatf("rgb errors line %0d", line), bad_c, 0);
      check($sformatf("hsync errors line %0d", line), bad_h, 0);
    end
    check("addresses above 12287", hi_addr, 0);
    check("red pixel count", reds, 25);

    pulse_and_restart("reset late", 2698);
    pulse_and_restart("reset at h300 v3", 20);

`ifdef VGA_TEST_PATTERN_EN
    pattern_sel = 1'b1;
    RESET_N = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    run_scan(800);
    check("bars x0", int'(cap_rgb[0]), 0);
    check("bars x79", int'(cap_rgb[79]), 0);
    check("bars x80", int'(cap_rgb[80]), 1);
    check("bars x160", int'(cap_rgb[160]), 2);
    check("bars x639", int'(cap_rgb[639]), 7);
    check("bars x640", int'(cap_rgb[640]), 0);
    check("bars hsync fall edge", hs_fall[0], 1316);
    check("bars hsync rise edge", hs_rise, 1316 + 192);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
